// File: rtl/keypad_operand_capture_pkg.sv
// Shared definitions for the keypad operand capture block: default key codes,
// the capture-state encoding and a digit classifier.
package keypad_pkg;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_BKSP  = 4'hB;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } cap_state_e;

   // Key codes 0-9 are decimal digits; 10-15 are function keys.
   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/keypad_operand_capture_shifter.sv
// bcd_digit_shifter: one operand register of N_DIGITS BCD nibbles plus the
// count of digits currently held. New digits enter at the least significant
// nibble; backspace drops the least significant nibble. flush clears the
// register unconditionally, the other operations only act while en is high.
module bcd_digit_shifter
   import keypad_pkg::*;
#(
   parameter  int N_DIGITS = 3,
   localparam int W        = N_DIGITS * 4,
   localparam int CNT_W    = $clog2(N_DIGITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             en,
   input  logic             shift_in,
   input  logic             shift_out,
   input  logic             clear,
   input  logic [3:0]       digit,
   output logic [W-1:0]     value,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N_DIGITS);

   logic [W+3:0] shifted_ext;
   logic         digit_ok;

   // Append the digit below the existing ones; the top nibble falls off the
   // end, which never matters because shifting stops once the register is full.
   always_comb begin
      shifted_ext = {value, digit};
      digit_ok    = is_digit(digit);
   end

   // Operand register and digit count.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         value <= '0;
         count <= '0;
      end else if (en) begin
         if (clear) begin
            value <= '0;
            count <= '0;
         end else if (shift_in && digit_ok && (count < MAX_CNT)) begin
            value <= shifted_ext[W-1:0];
            count <= count + 1'b1;
         end else if (shift_out && (count != '0)) begin
            value <= value >> 4;
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_operand_capture.sv
// keypad_operand_capture: collects N_OPERANDS BCD operands of up to N_DIGITS
// digits each from a keypad key stream and hands the complete set to the
// datapath over a valid/ready handshake. Key intake stalls while a finished
// set waits to be taken.
//
// Build option: define KEYPAD_BACKSPACE_EN to make BKSP_CODE remove the last
// typed digit of the current operand; otherwise BKSP_CODE is rejected like
// any other unused function key.
module keypad_operand_capture
   import keypad_pkg::*;
#(
   parameter  int         N_OPERANDS = 2,
   parameter  int         N_DIGITS   = 3,
   parameter  logic [3:0] ENTER_CODE = KEY_ENTER,
   parameter  logic [3:0] CLEAR_CODE = KEY_CLEAR,
   parameter  logic [3:0] BKSP_CODE  = KEY_BKSP,
   localparam int         OP_W       = N_DIGITS * 4,
   localparam int         IDX_W      = $clog2(N_OPERANDS + 1),
   localparam int         CNT_W      = $clog2(N_DIGITS + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   output logic                         key_ready,
   output logic [N_OPERANDS*OP_W-1:0]   operands,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [IDX_W-1:0]             op_idx,
   output logic [CNT_W-1:0]             digit_cnt,
   output logic                         key_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPERANDS - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(N_DIGITS);

   cap_state_e       state, state_nx;
   logic [IDX_W-1:0] op_idx_q;
   logic             key_err_q;
   logic             err_nx;

   logic             k_digit, k_enter, k_clear, k_bksp;
   logic             accept;
   logic             handshake;
   logic             do_shift, do_bksp, do_clear, do_enter;

   logic [CNT_W-1:0] cnt_arr [N_OPERANDS];
   logic [CNT_W-1:0] cur_cnt;

   assign op_idx    = op_idx_q;
   assign digit_cnt = cur_cnt;
   assign key_err   = key_err_q;

   // A finished set is taken when it is being held and the consumer is ready.
   assign handshake = (state == HOLD) && out_ready;

   // Classify the incoming key code.
   always_comb begin
      k_digit = is_digit(key_code);
      k_enter = (key_code == ENTER_CODE);
      k_clear = (key_code == CLEAR_CODE);
      k_bksp  = (key_code == BKSP_CODE);
   end

   // Digit count of the operand currently being typed.
   always_comb begin
      cur_cnt = '0;
      for (int i = 0; i < N_OPERANDS; i++) begin
         if (op_idx_q == IDX_W'(i)) cur_cnt = cnt_arr[i];
      end
   end

   // One operand register per operand; only the selected one reacts to keys,
   // and all of them are flushed when the set is handed over.
   for (genvar g = 0; g < N_OPERANDS; g++) begin : g_op
      logic sel;
      assign sel = (op_idx_q == IDX_W'(g));

      bcd_digit_shifter #(
         .N_DIGITS (N_DIGITS)
      ) u_shift (
         .clk       (clk),
         .rst       (rst),
         .flush     (handshake),
         .en        (sel),
         .shift_in  (do_shift),
         .shift_out (do_bksp),
         .clear     (do_clear),
         .digit     (key_code),
         .value     (operands[g*OP_W +: OP_W]),
         .count     (cnt_arr[g])
      );
   end

   // Capture state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next capture state: any accepted key starts or continues entry, ENTER on
   // the last operand freezes the set, the handshake returns to IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, ENTRY: begin
            if (key_valid) begin
               if (k_enter && (op_idx_q == LAST_IDX)) state_nx = HOLD;
               else                                   state_nx = ENTRY;
            end
         end
         HOLD: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs and the per-key action, including which keys are errors.
   always_comb begin
      key_ready = (state != HOLD);
      out_valid = (state == HOLD);
      accept    = key_valid && (state != HOLD);
      do_shift  = 1'b0;
      do_bksp   = 1'b0;
      do_clear  = 1'b0;
      do_enter  = 1'b0;
      err_nx    = 1'b0;
      if (accept) begin
         if (k_digit) begin
            if (cur_cnt == MAX_CNT) err_nx   = 1'b1;
            else                    do_shift = 1'b1;
         end else if (k_enter) begin
            do_enter = 1'b1;
         end else if (k_clear) begin
            do_clear = 1'b1;
`ifdef KEYPAD_BACKSPACE_EN
         end else if (k_bksp) begin
            if (cur_cnt == '0) err_nx  = 1'b1;
            else               do_bksp = 1'b1;
`else
         end else if (k_bksp) begin
            err_nx = 1'b1;
`endif
         end else begin
            err_nx = 1'b1;
         end
      end
   end

   // Operand index: advances on ENTER of a non-last operand, rewinds on handover.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_idx_q <= '0;
      end else if (handshake) begin
         op_idx_q <= '0;
      end else if (do_enter && (op_idx_q != LAST_IDX)) begin
         op_idx_q <= op_idx_q + 1'b1;
      end
   end

   // Rejected-key pulse, one cycle after the offending key.
   always_ff @(posedge clk) begin
      if (rst) key_err_q <= 1'b0;
      else     key_err_q <= err_nx;
   end

endmodule

// File: tb/tb_keypad_operand_capture.sv
// Directed bench for keypad_operand_capture with N_OPERANDS=2, N_DIGITS=3.
// Each table row gives the inputs held across one rising edge and the outputs
// expected just after that edge. Define KEYPAD_BACKSPACE_EN for both bench and
// design to exercise the backspace build.
module tb_keypad_operand_capture;

   logic        clk;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ready;
   logic [23:0] operands;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  op_idx;
   logic [1:0]  digit_cnt;
   logic        key_err;

   int checks = 0;
   int errors = 0;

   keypad_operand_capture #(
      .N_OPERANDS (2),
      .N_DIGITS   (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .operands  (operands),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op_idx    (op_idx),
      .digit_cnt (digit_cnt),
      .key_err   (key_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        kv;
      logic [3:0]  code;
      logic        ordy;
      logic [23:0] ops;
      logic        ov;
      logic        kr;
      logic [1:0]  idx;
      logic [1:0]  cnt;
      logic        err;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic kv, input logic [3:0] code,
                      input logic ordy, input logic [23:0] ops, input logic ov,
                      input logic kr, input logic [1:0] idx, input logic [1:0] cnt,
                      input logic err);
      vec_t v;
      v.rst = r; v.kv = kv; v.code = code; v.ordy = ordy;
      v.ops = ops; v.ov = ov; v.kr = kr; v.idx = idx; v.cnt = cnt; v.err = err;
      vq.push_back(v);
   endtask

   task automatic step(input logic r, input logic kv, input logic [3:0] code,
                       input logic ordy);
      @(negedge clk);
      rst       = r;
      key_valid = kv;
      key_code  = code;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [23:0] ops, input logic ov,
                           input logic kr, input logic [1:0] idx, input logic [1:0] cnt,
                           input logic err);
      chk({tag, " operands"}, {8'h0, operands}, {8'h0, ops});
      chk({tag, " ov/kr/idx/cnt/err"},
          {25'h0, out_valid, key_ready, op_idx, digit_cnt, key_err},
          {25'h0, ov, kr, idx, cnt, err});
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'h0;
      out_ready = 1'b0;

      //   rst   kv    code   ordy  operands      ov    kr    idx    cnt    err
      // reset
      add(1'b1, 1'b0, 4'h0, 1'b0, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      // 1,2,ENTER,3,ENTER then handover
      add(1'b0, 1'b1, 4'h1, 1'b0, 24'h000001, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
      add(1'b0, 1'b1, 4'h2, 1'b0, 24'h000012, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
      add(1'b0, 1'b1, 4'hA, 1'b0, 24'h000012, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0);
      add(1'b0, 1'b1, 4'h3, 1'b0, 24'h003012, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0);
      add(1'b0, 1'b1, 4'hA, 1'b0, 24'h003012, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0);
      add(1'b0, 1'b0, 4'h0, 1'b1, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      // 4,5,6,7: overflow on 7, then clear
      add(1'b0, 1'b1, 4'h4, 1'b0, 24'h000004, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
      add(1'b0, 1'b1, 4'h5, 1'b0, 24'h000045, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
      add(1'b0, 1'b1, 4'h6, 1'b0, 24'h000456, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0);
      add(1'b0, 1'b1, 4'h7, 1'b0, 24'h000456, 1'b0, 1'b1, 2'd0, 2'd3, 1'b1);
      add(1'b0, 1'b0, 4'h0, 1'b0, 24'h000456, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0);
      add(1'b0, 1'b1, 4'hC, 1'b0, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      // 9,9,CLEAR,8,ENTER,ENTER (empty second operand)
      add(1'b0, 1'b1, 4'h9, 1'b0, 24'h000009, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
      add(1'b0, 1'b1, 4'h9, 1'b0, 24'h000099, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
      add(1'b0, 1'b1, 4'hC, 1'b0, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      add(1'b0, 1'b1, 4'h8, 1'b0, 24'h000008, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
      add(1'b0, 1'b1, 4'hA, 1'b0, 24'h000008, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0);
      add(1'b0, 1'b1, 4'hA, 1'b0, 24'h000008, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
      // HOLD: keys dropped silently while out_ready is low, then handover
      add(1'b0, 1'b1, 4'h5, 1'b0, 24'h000008, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
      add(1'b0, 1'b1, 4'h5, 1'b0, 24'h000008, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
      add(1'b0, 1'b1, 4'h5, 1'b0, 24'h000008, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
      add(1'b0, 1'b0, 4'h0, 1'b1, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      // unknown function key
      add(1'b0, 1'b1, 4'hE, 1'b0, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
      add(1'b0, 1'b0, 4'h0, 1'b0, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      // 1,2,BKSP,3
      add(1'b0, 1'b1, 4'h1, 1'b0, 24'h000001, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
      add(1'b0, 1'b1, 4'h2, 1'b0, 24'h000012, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
`ifdef KEYPAD_BACKSPACE_EN
      add(1'b0, 1'b1, 4'hB, 1'b0, 24'h000001, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);
      add(1'b0, 1'b1, 4'h3, 1'b0, 24'h000013, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0);
`else
      add(1'b0, 1'b1, 4'hB, 1'b0, 24'h000012, 1'b0, 1'b1, 2'd0, 2'd2, 1'b1);
      add(1'b0, 1'b1, 4'h3, 1'b0, 24'h000123, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0);
`endif
      add(1'b0, 1'b1, 4'hC, 1'b0, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      // BKSP on an empty operand is rejected in either build
      add(1'b0, 1'b1, 4'hB, 1'b0, 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1);
      // out_ready without out_valid does nothing
      add(1'b0, 1'b1, 4'h7, 1'b1, 24'h000007, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].rst, vq[i].kv, vq[i].code, vq[i].ordy);
         chk_outs($sformatf("row%0d", i), vq[i].ops, vq[i].ov, vq[i].kr,
                  vq[i].idx, vq[i].cnt, vq[i].err);
      end

      // Reset in the middle of entering the second operand.
      step(1'b1, 1'b0, 4'h0, 1'b0);
      chk_outs("pre-reset", 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      step(1'b0, 1'b1, 4'h1, 1'b0);
      step(1'b0, 1'b1, 4'hA, 1'b0);
      step(1'b0, 1'b1, 4'h2, 1'b0);
      chk_outs("mid-entry", 24'h002001, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0);
      // rst wins over a simultaneous key
      step(1'b1, 1'b1, 4'h5, 1'b0);
      chk_outs("mid-reset", 24'h000000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
      step(1'b0, 1'b1, 4'h3, 1'b0);
      chk_outs("post-reset key", 24'h000003, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0);

      // Rejected key followed by a good one: key_err lasts exactly one cycle.
      step(1'b0, 1'b1, 4'hF, 1'b0);
      chk("err pulse hi", {31'h0, key_err}, 32'h1);
      step(1'b0, 1'b1, 4'h4, 1'b0);
      chk("err pulse lo", {31'h0, key_err}, 32'h0);
      chk("after F,4", {8'h0, operands}, 32'h000034);

      step(1'b0, 1'b0, 4'h0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
